// File: rtl/lc3_exec_pkg.sv
// Shared types and constants for the LC3 Execute stage.
// Holds the opcode map, e_control field encodings and offset sign-extension.
package lc3_exec_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned REG_W = 3;
  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OPC_W-1:0] OP_STR = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OPC_W-1:0] OP_STI = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OPC_W-1:0] OP_LEA = 4'b1110;

  // Encoding 2'b11 is reserved and yields a zero result.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_NOT = 2'b10
  } alu_ctl_e;

  typedef enum logic [1:0] {
    PCS1_ZERO  = 2'b00,
    PCS1_OFF6  = 2'b01,
    PCS1_OFF9  = 2'b10,
    PCS1_OFF11 = 2'b11
  } pcsel1_e;

  typedef struct packed {
    alu_ctl_e alu_control;
    pcsel1_e  pcselect1;
    logic     pcselect2;
    logic     op2select;
  } e_control_t;

  // Sign-extended address offset drawn from the low instruction bits.
  function automatic logic [WIDTH-1:0] sext_offset(pcsel1_e sel, logic [10:0] field);
    logic [WIDTH-1:0] off;
    off = '0;
    case (sel)
      PCS1_OFF11: off = {{(WIDTH-11){field[10]}}, field[10:0]};
      PCS1_OFF9:  off = {{(WIDTH-9){field[8]}}, field[8:0]};
      PCS1_OFF6:  off = {{(WIDTH-6){field[5]}}, field[5:0]};
      default:    off = '0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// Decode-to-Execute bundle plus Execute results toward MemAccess/Writeback.
interface lc3_execute_if;
  import lc3_exec_pkg::*;

  e_control_t        e_control;
  logic [1:0]        w_control_in;
  logic              mem_control_in;
  logic [WIDTH-1:0]  npc_in;
  logic [WIDTH-1:0]  ir;
  logic [WIDTH-1:0]  vsr1;
  logic [WIDTH-1:0]  vsr2;
  logic              bypass_alu_1;
  logic              bypass_alu_2;
  logic              bypass_mem_1;
  logic              bypass_mem_2;
  logic [WIDTH-1:0]  mem_bypass_val;

  logic [WIDTH-1:0]  aluout;
  logic [WIDTH-1:0]  pcout;
  logic [1:0]        w_control_out;
  logic              mem_control_out;
  logic [WIDTH-1:0]  m_data;
  logic [REG_W-1:0]  dr;
  logic [WIDTH-1:0]  ir_exec;
  logic [2:0]        nzp;
  logic [REG_W-1:0]  sr1;
  logic [REG_W-1:0]  sr2;

  modport master (
    output e_control, w_control_in, mem_control_in, npc_in, ir, vsr1, vsr2,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_bypass_val,
    input  aluout, pcout, w_control_out, mem_control_out, m_data, dr, ir_exec,
           nzp, sr1, sr2
  );

  modport slave (
    input  e_control, w_control_in, mem_control_in, npc_in, ir, vsr1, vsr2,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_bypass_val,
    output aluout, pcout, w_control_out, mem_control_out, m_data, dr, ir_exec,
           nzp, sr1, sr2
  );

endinterface

// File: rtl/lc3_exec_alu.sv
// Combinational LC3 ALU: ADD, AND, NOT; reserved control yields zero.
module lc3_exec_alu
  import lc3_exec_pkg::*;
(
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  alu_ctl_e         alu_control,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = op1 + op2;
      ALU_AND: result = op1 & op2;
      ALU_NOT: result = ~op1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lc3_execute.sv
// LC3 Execute stage: operand bypass, ALU / effective-address compute,
// branch condition mask and register-file source selects.
module lc3_execute
  import lc3_exec_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           enable_execute,
  lc3_execute_if.slave   bus
);

  logic [OPC_W-1:0] opcode;
  e_control_t       ectl;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] addr;
  logic             is_alu_op;
  logic [2:0]       nzp_next;

  logic [WIDTH-1:0] aluout_q;
  logic [WIDTH-1:0] pcout_q;
  logic [1:0]       w_control_q;
  logic             mem_control_q;
  logic [WIDTH-1:0] m_data_q;
  logic [REG_W-1:0] dr_q;
  logic [WIDTH-1:0] ir_exec_q;
  logic [2:0]       nzp_q;

  assign opcode = bus.ir[15:12];
  assign ectl   = bus.e_control;

  // Register-file source selects; stores read their data register through sr2.
  assign bus.sr1 = bus.ir[8:6];
  assign bus.sr2 = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI)
                   ? bus.ir[11:9] : bus.ir[2:0];

  // ALU forwarding beats MemAccess forwarding; it is the younger result.
  always_comb begin
    op1 = bus.vsr1;
    if (bus.bypass_alu_1)      op1 = aluout_q;
    else if (bus.bypass_mem_1) op1 = bus.mem_bypass_val;
    op2 = bus.vsr2;
    if (bus.bypass_alu_2)      op2 = aluout_q;
    else if (bus.bypass_mem_2) op2 = bus.mem_bypass_val;
  end

  assign alu_b = ectl.op2select ? op2 : {{(WIDTH-5){bus.ir[4]}}, bus.ir[4:0]};

  lc3_exec_alu u_alu (
    .op1         (op1),
    .op2         (alu_b),
    .alu_control (ectl.alu_control),
    .result      (alu_res)
  );

  assign offset = sext_offset(ectl.pcselect1, bus.ir[10:0]);
  assign base   = ectl.pcselect2 ? bus.npc_in : op1;
  assign addr   = base + offset;

  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);

  always_comb begin
    nzp_next = 3'b000;
    if (opcode == OP_BR)       nzp_next = bus.ir[11:9];
    else if (opcode == OP_JMP) nzp_next = 3'b111;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
      m_data_q      <= '0;
      dr_q          <= '0;
      ir_exec_q     <= '0;
      nzp_q         <= '0;
    end else if (enable_execute) begin
      aluout_q      <= is_alu_op ? alu_res : addr;
      pcout_q       <= addr;
      w_control_q   <= bus.w_control_in;
      mem_control_q <= bus.mem_control_in;
      m_data_q      <= op2;
      dr_q          <= bus.ir[11:9];
      ir_exec_q     <= bus.ir;
      nzp_q         <= nzp_next;
    end
  end

  assign bus.aluout          = aluout_q;
  assign bus.pcout           = pcout_q;
  assign bus.w_control_out   = w_control_q;
  assign bus.mem_control_out = mem_control_q;
  assign bus.m_data          = m_data_q;
  assign bus.dr              = dr_q;
  assign bus.ir_exec         = ir_exec_q;
  assign bus.nzp             = nzp_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed + random bench for lc3_execute with an expected-result scoreboard.
module tb_lc3_execute;
  import lc3_exec_pkg::*;

  typedef struct packed {
    logic [15:0] ir;
    logic [5:0]  ectl;
    logic [1:0]  wc;
    logic        mc;
    logic [15:0] npc;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic        ba1;
    logic        ba2;
    logic        bm1;
    logic        bm2;
    logic [15:0] mbv;
  } stim_t;

  typedef struct packed {
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [1:0]  wc;
    logic        mc;
    logic [15:0] m_data;
    logic [2:0]  dr;
    logic [15:0] ir_exec;
    logic [2:0]  nzp;
  } exp_t;

  logic  clk;
  logic  rst_n;
  logic  en;
  int    checks;
  int    errors;
  exp_t  sb[$];
  exp_t  model_q;
  stim_t s;

  lc3_execute_if bus ();

  lc3_execute dut (
    .clock          (clk),
    .reset          (rst_n),
    .enable_execute (en),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input stim_t st, input logic [15:0] prev);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] opb;
    logic [15:0] res;
    logic [15:0] off;
    logic [15:0] base;
    logic [3:0]  opc;
    exp_t        e;
    a   = st.ba1 ? prev : (st.bm1 ? st.mbv : st.vsr1);
    b   = st.ba2 ? prev : (st.bm2 ? st.mbv : st.vsr2);
    opb = st.ectl[0] ? b : {{11{st.ir[4]}}, st.ir[4:0]};
    case (st.ectl[5:4])
      2'b00:   res = a + opb;
      2'b01:   res = a & opb;
      2'b10:   res = ~a;
      default: res = 16'h0000;
    endcase
    case (st.ectl[3:2])
      2'b11:   off = {{5{st.ir[10]}}, st.ir[10:0]};
      2'b10:   off = {{7{st.ir[8]}}, st.ir[8:0]};
      2'b01:   off = {{10{st.ir[5]}}, st.ir[5:0]};
      default: off = 16'h0000;
    endcase
    base      = st.ectl[1] ? st.npc : a;
    opc       = st.ir[15:12];
    e.pcout   = base + off;
    e.aluout  = (opc == 4'd1 || opc == 4'd5 || opc == 4'd9) ? res : e.pcout;
    e.wc      = st.wc;
    e.mc      = st.mc;
    e.m_data  = b;
    e.dr      = st.ir[11:9];
    e.ir_exec = st.ir;
    e.nzp     = (opc == 4'd0) ? st.ir[11:9] : ((opc == 4'd12) ? 3'b111 : 3'b000);
    return e;
  endfunction

  task automatic apply(input stim_t st);
    bus.ir             = st.ir;
    bus.e_control      = e_control_t'(st.ectl);
    bus.w_control_in   = st.wc;
    bus.mem_control_in = st.mc;
    bus.npc_in         = st.npc;
    bus.vsr1           = st.vsr1;
    bus.vsr2           = st.vsr2;
    bus.bypass_alu_1   = st.ba1;
    bus.bypass_alu_2   = st.ba2;
    bus.bypass_mem_1   = st.bm1;
    bus.bypass_mem_2   = st.bm2;
    bus.mem_bypass_val = st.mbv;
  endtask

  // Drive one cycle: check source selects, push expected, clock, pop and compare.
  task automatic run_cycle(input stim_t st);
    exp_t        e;
    exp_t        got;
    logic [3:0]  opc;
    logic [2:0]  sr2_exp;
    apply(st);
    #1;
    opc     = st.ir[15:12];
    sr2_exp = (opc == 4'd3 || opc == 4'd7 || opc == 4'd11) ? st.ir[11:9] : st.ir[2:0];
    chk("sr1", 16'(bus.sr1), 16'(st.ir[8:6]));
    chk("sr2", 16'(bus.sr2), 16'(sr2_exp));
    if (!rst_n)  e = '0;
    else if (en) e = model(st, model_q.aluout);
    else         e = model_q;
    sb.push_back(e);
    model_q = e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      got = sb.pop_front();
      chk("aluout",          bus.aluout,               got.aluout);
      chk("pcout",           bus.pcout,                got.pcout);
      chk("w_control_out",   16'(bus.w_control_out),   16'(got.wc));
      chk("mem_control_out", 16'(bus.mem_control_out), 16'(got.mc));
      chk("m_data",          bus.m_data,               got.m_data);
      chk("dr",              16'(bus.dr),              16'(got.dr));
      chk("ir_exec",         bus.ir_exec,              got.ir_exec);
      chk("nzp",             16'(bus.nzp),             16'(got.nzp));
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t r;
    r = stim_t'({$urandom, $urandom, $urandom, $urandom});
    return r;
  endfunction

  initial begin
    clk     = 1'b0;
    checks  = 0;
    errors  = 0;
    model_q = '0;
    rst_n   = 1'b0;
    en      = 1'b1;
    s       = '0;
    apply(s);
    @(posedge clk);
    #1;

    // Reset with busy nonzero inputs
    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.wc = 2'b11; s.mc = 1'b1; s.ir = 16'h1265; s.vsr2 = 16'hBEEF;
      run_cycle(s);
    end
    chk("reset_aluout", bus.aluout, 16'h0000);

    // ADD R1,R1,#5 with wraparound
    rst_n = 1'b1;
    s = '0; s.ir = 16'h1265; s.vsr1 = 16'hFFFE; s.ectl = 6'b00_00_0_0;
    run_cycle(s);
    chk("add_imm_aluout", bus.aluout, 16'h0003);
    chk("add_imm_dr", 16'(bus.dr), 16'd1);

    // Prime aluout = 0F0F, then AND with both op1 bypasses: ALU path wins
    s = '0; s.ir = 16'h1265; s.vsr1 = 16'h0F0A; s.ectl = 6'b00_00_0_0;
    run_cycle(s);
    s = '0; s.ir = 16'h5042; s.vsr1 = 16'h00FF; s.vsr2 = 16'hFFFF; s.mbv = 16'h3333;
    s.ba1 = 1'b1; s.bm1 = 1'b1; s.ectl = 6'b01_00_0_1;
    run_cycle(s);
    chk("bypass_prio_aluout", bus.aluout, 16'h0F0F);

    // BRnp #-2 from npc 3001
    s = '0; s.ir = 16'h0BFE; s.npc = 16'h3001; s.ectl = 6'b00_10_1_0;
    run_cycle(s);
    chk("br_pcout", bus.pcout, 16'h2FFF);
    chk("br_aluout", bus.aluout, 16'h2FFF);
    chk("br_nzp", 16'(bus.nzp), 16'(3'b101));

    // STR R5,R2,#3
    s = '0; s.ir = 16'h7A83; s.vsr1 = 16'h4000; s.vsr2 = 16'hBEEF; s.mc = 1'b1;
    s.wc = 2'b10; s.ectl = 6'b00_01_0_1;
    run_cycle(s);
    chk("str_pcout", bus.pcout, 16'h4003);
    chk("str_m_data", bus.m_data, 16'hBEEF);
    chk("str_mem_control", 16'(bus.mem_control_out), 16'd1);

    // NOT with MemAccess forwarding on op1
    s = '0; s.ir = 16'h927F; s.vsr1 = 16'h1234; s.bm1 = 1'b1; s.mbv = 16'h00F0;
    s.ectl = 6'b10_00_0_0;
    run_cycle(s);
    chk("not_mem_bypass", bus.aluout, 16'hFF0F);

    // Reserved ALU control on an ADD opcode
    s = '0; s.ir = 16'h1481; s.vsr1 = 16'h1111; s.vsr2 = 16'h2222; s.ectl = 6'b11_00_0_1;
    run_cycle(s);
    chk("alu_reserved", bus.aluout, 16'h0000);

    // JMP R3 then dependent ADD R2,R2,R1 forwarding both operands from aluout
    s = '0; s.ir = 16'hC0C0; s.vsr1 = 16'h5000; s.ectl = 6'b00_00_0_0;
    run_cycle(s);
    chk("jmp_nzp", 16'(bus.nzp), 16'(3'b111));
    s = '0; s.ir = 16'h1481; s.ba1 = 1'b1; s.ba2 = 1'b1; s.ectl = 6'b00_00_0_1;
    run_cycle(s);
    chk("b2b_add", bus.aluout, 16'hA000);

    // Mid-stream reset discards the in-flight instruction
    rst_n = 1'b0;
    s = '0; s.ir = 16'h1265; s.vsr1 = 16'h7777;
    run_cycle(s);
    chk("midreset_aluout", bus.aluout, 16'h0000);
    rst_n = 1'b1;
    s = '0; s.ir = 16'h1265; s.vsr1 = 16'h0010; s.wc = 2'b01;
    run_cycle(s);
    chk("after_reset_load", bus.aluout, 16'h0015);

    // Hold: enable low while inputs toggle
    en = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle(rand_stim());
    chk("hold_aluout", bus.aluout, 16'h0015);
    chk("hold_ir_exec", bus.ir_exec, 16'h1265);
    en = 1'b1;

    // Random traffic with occasional stalls
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 4) != 0);
      run_cycle(rand_stim());
    end
    en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_execute.md
Name: lc3_execute

Overview:
- LC3 Execute pipeline stage, directly downstream of Decode; consumes the decode_out bundle (e_control, w_control, mem_control, npc_out, ir).
- Resolves operand bypasses, performs ALU (ADD/AND/NOT) or address computation (PC/base + sign-extended offset) and registers the results for the MemAccess/Writeback stages.
- Drives the branch condition mask and the register-file source selects.

Parameters:
- WIDTH, 16, datapath/address width (LC3 fixes 16; other values unsupported).

Ports:
- clock  in  1  stage clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- enable_execute  in  1  stage enable from controller; 0 = hold all registers
- e_control  in  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- w_control_in  in  2  writeback select, passed through
- mem_control_in  in  1  memory-access control, passed through
- npc_in  in  16  PC+1 of instruction in Execute
- ir  in  16  instruction in Execute
- vsr1, vsr2  in  16  register-file read data for sr1/sr2
- bypass_alu_1, bypass_alu_2  in  1  replace operand 1/2 with registered aluout
- bypass_mem_1, bypass_mem_2  in  1  replace operand 1/2 with mem_bypass_val
- mem_bypass_val  in  16  MemAccess forwarding value
- aluout  out  16  registered ALU or effective-address result
- pcout  out  16  registered branch/jump target
- w_control_out  out  2  registered w_control_in
- mem_control_out  out  1  registered mem_control_in
- m_data  out  16  registered store data (bypassed operand 2)
- dr  out  3  registered destination register, ir[11:9]
- ir_exec  out  16  registered ir
- nzp  out  3  registered branch condition mask
- sr1, sr2  out  3  combinational register-file source selects

Behaviour:
- Reset (reset==0 at clock edge): aluout, pcout, m_data, ir_exec = 0; w_control_out = 0; mem_control_out = 0; dr = 0; nzp = 0. Reset wins over enable_execute.
- Latency: one cycle; outputs reflect inputs sampled on the edge where enable_execute==1. enable_execute==0: every registered output holds.
- sr1 = ir[8:6] always.
- sr2 = ir[11:9] for ST/STR/STI (opcodes 0011/0111/1011); otherwise ir[2:0]. Combinational, no reset dependence.
- Operand select, per operand (op1 from vsr1, op2 from vsr2): bypass_alu_x → registered aluout; else bypass_mem_x → mem_bypass_val; else vsr. If both bypasses are asserted, ALU wins.
- op2select: 1 = bypassed op2; 0 = sext(ir[4:0]).
- ALU ops (opcodes 0001 ADD, 0101 AND, 1001 NOT): alu_control 00 = op1+op2 mod 2^16; 01 = op1&op2; 10 = ~op1; 11 = reserved, result 0. aluout = ALU result.
- Offset selection by pcselect1: 11 = sext(ir[10:0]), 10 = sext(ir[8:0]), 01 = sext(ir[5:0]), 00 = 0.
- Address computation: base = pcselect2 ? npc_in : op1. pcout = base + offset mod 2^16 (wraps silently, no carry out).
- All non-ALU opcodes: aluout = same value as pcout.
- nzp: BR (0000) → ir[11:9]; JMP (1100) → 3'b111; all other opcodes → 3'b000.
- m_data = bypassed op2 regardless of opcode; consumers qualify it with mem_control_out.
- Bypass of aluout uses the value currently registered, so back-to-back dependent ALU ops resolve with zero stall.
- Reset asserted mid-stream: in-flight instruction is discarded; the first enabled cycle after reset release loads fresh inputs.

Decomposition:
- Shared package lc3_exec_pkg:
  - opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_LD, OP_LDR, OP_LDI, OP_LEA, OP_ST, OP_STR, OP_STI)
  - alu_control enum (ALU_ADD, ALU_AND, ALU_NOT)
  - pcselect1 enum
  - e_control packed struct matching the bit order above
- One combinational sub-module, lc3_exec_alu: operands + alu_control in, result out. Bypass muxes, address adder and output registers stay in lc3_execute.

Test Plan:
- Reset: drive reset=0 for 2 cycles with nonzero inputs → all registered outputs 0; release with enable_execute=1 → outputs load on the next edge.
- ADD imm: ir=16'h1265 (ADD R1,R1,#5), vsr1=16'hFFFE, op2select=0, alu_control=00 → aluout=16'h0003 (wrap), dr=3'd1, nzp=0, sr1=3'd1.
- Bypass priority: AND reg form ir=16'h5042, vsr1=16'h00FF, registered aluout=16'h0F0F, mem_bypass_val=16'h3333, bypass_alu_1=1 and bypass_mem_1=1, vsr2=16'hFFFF → aluout=16'h0F0F.
- BR target: ir=16'h0BFE (BRnp #-2), npc_in=16'h3001, pcselect1=10, pcselect2=1 → pcout=16'h2FFF, aluout=16'h2FFF, nzp=3'b101.
- Store data: ir=16'h7A83 (STR R5,R2,#3), vsr1=16'h4000, vsr2=16'hBEEF, pcselect1=01, pcselect2=0 → sr2=3'd5, pcout=16'h4003, m_data=16'hBEEF, mem_control_out=mem_control_in.
- Hold: after a load, drop enable_execute=0 for 3 cycles while toggling all inputs → all registered outputs unchanged; sr1/sr2 still follow ir combinationally.
